// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Provides the fetch FSM encoding, NOP word, PC step/alignment and a PC align helper.
package cpu_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INST      = 32'h0000_0000;
    localparam logic [31:0] PC_STEP       = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return a & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: reset load, +4 advance from a base, aligned redirect.
// Ports: clk, rst_n (sync, active-low), redirect/redirect_pc, advance/advance_base,
// pc (registered value), pc_next (value pc takes at the next edge).
import cpu_fetch_pkg::*;

module fetch_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        advance,
    input  logic [31:0] advance_base,
    output logic [31:0] pc,
    output logic [31:0] pc_next
);

    // Redirect outranks a sequential advance; the add wraps modulo 2^32.
    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = align_pc(redirect_pc);
        end else if (advance) begin
            pc_next = advance_base + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over imem req/ack and
// hands one registered instruction to the decoder with valid/ready.
// Ports: clk, rst_n (sync, active-low); imem_req/imem_addr/imem_ack/imem_rdata;
// inst_out/pc_out/pc_plus4/inst_valid/inst_ready to decode;
// redirect_valid/redirect_pc from branch resolution; fetch_timeout sticky flag.
import cpu_fetch_pkg::*;

module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_timeout
);

    localparam logic [16:0] LIMIT = 17'(WAIT_LIMIT);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_next;
    logic         squash;
    logic [15:0]  wait_cnt;
    logic         accept;

    // Data is kept only when nothing has redirected the PC since the request.
    assign accept = (state == ST_REQ) && imem_ack
                    && !squash && !redirect_valid;

    assign pc_plus4 = pc_out + PC_STEP;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk          (clk),
        .rst_n        (rst_n),
        .redirect     (redirect_valid),
        .redirect_pc  (redirect_pc),
        .advance      (accept),
        .advance_base (imem_addr),
        .pc           (pc),
        .pc_next      (pc_next)
    );

    // imem_addr doubles as the captured request address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            imem_req      <= 1'b0;
            imem_addr     <= RESET_PC;
            inst_out      <= NOP_INST;
            pc_out        <= RESET_PC;
            inst_valid    <= 1'b0;
            squash        <= 1'b0;
            wait_cnt      <= 16'd0;
            fetch_timeout <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state     <= ST_REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= pc_next;
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        wait_cnt <= 16'd0;
                        squash   <= 1'b0;
                        if (accept) begin
                            inst_out   <= imem_rdata;
                            pc_out     <= imem_addr;
                            inst_valid <= 1'b1;
                            imem_req   <= 1'b0;
                            state      <= ST_VALID;
                        end else begin
                            imem_addr <= pc_next;
                        end
                    end else begin
                        if (redirect_valid) begin
                            squash <= 1'b1;
                        end
                        if (wait_cnt != 16'hFFFF) begin
                            wait_cnt <= wait_cnt + 16'd1;
                        end
                        if ({1'b0, wait_cnt} + 17'd1 >= LIMIT) begin
                            fetch_timeout <= 1'b1;
                        end
                    end
                end
                ST_VALID: begin
                    if (redirect_valid || inst_ready) begin
                        inst_valid <= 1'b0;
                        imem_req   <= 1'b1;
                        imem_addr  <= pc_next;
                        state      <= ST_REQ;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
